// File: rtl/receiver_uart_rx.sv
// UART receive path: 2-FF synchronised rx, mid-bit sampling, 8 data bits LSB first,
// optional even parity, one stop bit; each byte is reported with a one-cycle valid pulse.
module receiver_uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic       parity_en,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    // CLKS_PER_BIT >= 4 keeps the half-bit point strictly inside the start bit.
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_en_q, par_en_d;
    logic          pbit_q, pbit_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    logic          rxs;
    logic          bit_end;
    logic          half_end;
    logic          shift_en;

    assign sync_d   = {sync_q[0], rx_i};
    assign rxs      = sync_q[1];
    assign bit_end  = (cnt_q == CNT_FULL);
    assign half_end = (cnt_q == CNT_HALF);

    // Each shift-register bit only loads when the sampled bit index points at it.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sh
            assign sh_d[gi] = (shift_en && (idx_q == 3'(gi))) ? rxs : sh_q[gi];
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        par_en_d = par_en_q;
        pbit_d   = pbit_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        shift_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d  = S_START;
                    par_en_d = parity_en;
                end
            end

            S_START: begin
                if (half_end) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    shift_en = 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    pbit_d  = rxs;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    data_d  = sh_q;
                    ferr_d  = ~rxs;
                    perr_d  = par_en_q & (pbit_q ^ (^sh_q));
                    // A low stop bit means a break; wait for the line to recover.
                    state_d = rxs ? S_IDLE : S_BREAK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_BREAK: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b11;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            sh_q     <= 8'h00;
            par_en_q <= 1'b0;
            pbit_q   <= 1'b0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            par_en_q <= par_en_d;
            pbit_q   <= pbit_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_receiver_uart_rx.sv
// Bench for receiver_uart_rx: directed vector table, multi-cycle corner sequences,
// and random frames checked against a parity/framing reference model.
module tb_receiver_uart_rx;

    localparam int CLKS = 16;

    logic       clk;
    logic       rst;
    logic       rx_i;
    logic       parity_en;
    logic [7:0] data_o;
    logic       valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       busy_o;

    receiver_uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .parity_en    (parity_en),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       pbit;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t got_q[$];
    rec_t exp_q[$];
    rec_t last_exp;
    logic prev_valid = 1'b0;
    vec_t vecs[10];

    task automatic check_b(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic check_n(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Capture every valid pulse; a pulse must never follow another directly.
    always @(negedge clk) begin
        if (valid_o) begin
            got_q.push_back('{d: data_o, pe: parity_err_o, fe: frame_err_o});
            check_b("valid_single_cycle", prev_valid, 1'b0);
        end
        prev_valid = valid_o;
    end

    // Reference: even parity computed by counting ones in the byte.
    function automatic rec_t model(input logic [7:0] d, input logic pen,
                                   input logic pbit, input logic stop);
        int   ones;
        rec_t r;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        r.d  = d;
        r.pe = pen && (pbit != ((ones % 2) == 1));
        r.fe = !stop;
        return r;
    endfunction

    task automatic push_exp(input rec_t r);
        exp_q.push_back(r);
        last_exp = r;
    endtask

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx_i = 1'b1;
        repeat (n * CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pen_after,
                              input logic pbit, input logic stop);
        parity_en = pen;
        drive_bit(1'b0);
        parity_en = pen_after;
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic compare_all(input string name);
        rec_t g;
        rec_t e;
        check_n({name, ".count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            $display("frame %s: data=%02h perr=%0b ferr=%0b (want %02h %0b %0b)",
                     name, g.d, g.pe, g.fe, e.d, e.pe, e.fe);
            check_v({name, ".data"}, g.d, e.d);
            check_b({name, ".perr"}, g.pe, e.pe);
            check_b({name, ".ferr"}, g.fe, e.fe);
        end
        got_q.delete();
        exp_q.delete();
        check_v({name, ".held_data"}, data_o, last_exp.d);
        check_b({name, ".held_perr"}, parity_err_o, last_exp.pe);
        check_b({name, ".held_ferr"}, frame_err_o, last_exp.fe);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rpen;
        logic       rpbit;
        logic       rstop;
        int         gap;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[2] = '{8'hAA, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[7] = '{8'h7E, 1'b1, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1};
        vecs[8] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[9] = '{8'h96, 1'b1, 1'b1, 1'b0, 8'h96, 1'b1, 1'b1};

        rst       = 1'b1;
        rx_i      = 1'b1;
        parity_en = 1'b0;
        last_exp  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_v("reset.data", data_o, 8'h00);
        check_b("reset.valid", valid_o, 1'b0);
        check_b("reset.perr", parity_err_o, 1'b0);
        check_b("reset.ferr", frame_err_o, 1'b0);
        check_b("reset.busy", busy_o, 1'b0);
        idle_bits(2);

        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].pen, vecs[i].pen, vecs[i].pbit, vecs[i].stop);
            idle_bits(2);
            push_exp('{d: vecs[i].exp_data, pe: vecs[i].exp_perr, fe: vecs[i].exp_ferr});
            compare_all($sformatf("vec%0d", i));
            check_b($sformatf("vec%0d.busy_idle", i), busy_o, 1'b0);
        end

        // Short low glitch: start bit rejected at its midpoint.
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        check_b("glitch.busy_high", busy_o, 1'b1);
        idle_bits(2);
        check_b("glitch.busy_low", busy_o, 1'b0);
        compare_all("glitch");

        // Line held low for 40 bit times after a frame with a low stop bit.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        rx_i = 1'b0;
        repeat (40 * CLKS) @(negedge clk);
        check_b("break.busy", busy_o, 1'b1);
        push_exp('{d: 8'h3C, pe: 1'b0, fe: 1'b1});
        compare_all("break");
        idle_bits(2);
        check_b("break.recover_busy", busy_o, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        push_exp('{d: 8'h55, pe: 1'b0, fe: 1'b0});
        compare_all("after_break");

        // Reset in the middle of data bit 4 drops the frame.
        parity_en = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx_i = 1'b1;
        repeat (CLKS / 2) @(negedge clk);
        check_b("midrst.busy_before", busy_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_v("midrst.data", data_o, 8'h00);
        check_b("midrst.valid", valid_o, 1'b0);
        check_b("midrst.perr", parity_err_o, 1'b0);
        check_b("midrst.ferr", frame_err_o, 1'b0);
        check_b("midrst.busy", busy_o, 1'b0);
        last_exp = '0;
        idle_bits(12);
        compare_all("midrst_drop");
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_bits(1);
        push_exp('{d: 8'h81, pe: 1'b0, fe: 1'b0});
        compare_all("after_midrst");

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        push_exp('{d: 8'h00, pe: 1'b0, fe: 1'b0});
        push_exp('{d: 8'hFF, pe: 1'b0, fe: 1'b0});
        compare_all("b2b");

        // Random frames, random gaps, parity_en toggled mid-frame.
        for (int n = 0; n < 40; n++) begin
            rd    = 8'($urandom_range(0, 255));
            rpen  = 1'($urandom_range(0, 1));
            rpbit = 1'($urandom_range(0, 1));
            rstop = ($urandom_range(0, 3) != 0);
            send_frame(rd, rpen, 1'($urandom_range(0, 1)), rpbit, rstop);
            push_exp(model(rd, rpen, rpbit, rstop));
            compare_all($sformatf("rand%0d", n));
            gap = rstop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            if (gap > 0) idle_bits(gap);
        end
        idle_bits(2);
        compare_all("rand_tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
